mmio_uart_fifo: RTL
===================

// Module: mmio_uart_fifo
// PURPOSE
//  Memory-mapped UART peripheral for the SoC IO page. It replaces the bare single-byte TX/RX pair.
//  Adds per-direction FIFOs, a runtime baud divisor, sticky error flags and a level interrupt.
//  Sits behind the CPU bus decode: the SoC asserts sel when the access targets the UART window.
// PARAMETERS
//  TX_DEPTH      16   TX FIFO entries, power of 2, >=2
//  RX_DEPTH      16   RX FIFO entries, power of 2, >=2
//  DIV_RESET     234  reset value of DIVISOR, clk cycles per bit (27 MHz / 115200)
// PORTS
//  clk        in   1   system clock
//  resetn     in   1   synchronous, active-low reset
//  sel        in   1   access targets this block
//  reg_addr   in   2   word index in window (mem_addr[3:2])
//  wdata      in   32  write data
//  wstrb      in   1   write strobe (OR of wmask), one cycle per write
//  rstrb      in   1   read strobe, one cycle per read
//  rdata      out  32  read data, registered
//  irq        out  1   level interrupt
//  rx         in   1   serial input, asynchronous
//  tx         out  1   serial output, idle high
// BEHAVIOUR
//  Registers: 0 DATA, 1 STATUS, 2 DIVISOR, 3 IRQ_EN. Accesses with sel=0 are ignored.
//  Reset: tx=1, rdata=0, irq=0, FIFOs empty, sticky flags 0, DIVISOR=DIV_RESET, IRQ_EN=0, both FSMs IDLE.
//   Reset mid-frame aborts the frame; tx returns high on the next edge.
//  Read latency: rdata is valid on the cycle after rstrb and holds until the next rstrb.
//  DATA write: pushes wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
//  DATA read: rdata = {23'b0, valid, byte}.
//   If RX is non-empty, valid=1 and the head entry is popped.
//   If RX is empty, rdata = 0 and nothing is popped.
//  STATUS read, bits:
//   [0] tx_full  [1] tx_empty  [2] rx_empty  [3] rx_full  [4] tx_busy (FSM not IDLE)
//   [5] rx_ovr   [6] frame_err [7] tx_ovf    [15:8] rx_count  [31:16] 0
//  STATUS write: a 1 in bits [7:5] clears the matching sticky flag.
//   If the same event recurs in that cycle, set wins over clear.
//  DIVISOR: bits [15:0]. A written value below 4 is stored as 4. Reads return the stored value.
//  IRQ_EN: bits [1:0].
//  irq: registered, = (en[0] & !rx_empty) | (en[1] & tx_empty).
//  FIFO full/empty checks use the occupancy at the start of the cycle.
//   A push to a full FIFO is dropped even if a pop occurs in the same cycle.
//   Pop and push on a non-empty, non-full FIFO in the same cycle both take effect; count is unchanged.
//   Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: when the FIFO is non-empty, pop it, latch the byte and latch DIVISOR, then go to START.
//   Each state lasts DIV cycles. START drives 0. DATA sends 8 bits LSB first. STOP drives 1.
//   From STOP, go to IDLE, which can pop again the next cycle (1 idle cycle between frames).
//   A DIVISOR write mid-frame takes effect at the next frame.
//  RX path: rx passes through a 2-FF synchronizer (2 cycles added latency).
//  RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: on a synced falling edge, latch DIVISOR and wait DIV/2 cycles.
//   START: if the line is still 0 go to DATA, else treat as a glitch and return to IDLE.
//   DATA: sample every DIV cycles, 8 bits, LSB first.
//   STOP: sample once.
//    Sample = 1: push the byte; if the RX FIFO is full, drop it and set rx_ovr.
//    Sample = 0: set frame_err, discard the byte, and return to IDLE only once the line reads 1.
// TESTING
//  DIVISOR<=4, write DATA=0x55 -> tx: start low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high 4 cycles; tx_busy=1 throughout.
//  Loopback tx->rx, DIVISOR=8, write 0xA5,0x3C -> rx_count=2; DATA reads return 0x1A5 then 0x13C; a third read returns 0x000.
//  With TX stalled (tx_busy=1 on a frame), write 17 more bytes -> 16 accepted, tx_full=1, tx_ovf=1; STATUS write 0x80 clears tx_ovf.
//  Drive an rx frame with stop bit=0 -> frame_err=1, rx_count=0; send 17 valid frames with no reads -> rx_full=1, rx_ovr=1.
//  rx low pulse of DIV/2-1 cycles -> no byte, no error. Write DIVISOR=1 -> reads back 4.
//  IRQ_EN=1, receive 1 byte -> irq=1; read DATA -> irq=0 within 2 cycles. Assert resetn=0 mid-TX-frame -> tx=1 the next cycle, STATUS=0x06.

Source files
------------

// File: rtl/mmio_uart_fifo.sv
// mmio_uart_fifo: memory-mapped UART for the SoC IO page. It has a TX FIFO and an
// RX FIFO, a baud divisor that can be changed at run time, sticky error flags and a
// level interrupt.
//
// Ports:
//   clk       system clock
//   resetn    synchronous, active-low reset
//   sel       the bus access targets this block
//   reg_addr  word index: 0 DATA, 1 STATUS, 2 DIVISOR, 3 IRQ_EN
//   wdata     write data
//   wstrb     one-cycle write strobe
//   rstrb     one-cycle read strobe
//   rdata     registered read data, valid the cycle after rstrb
//   irq       registered level interrupt
//   rx        asynchronous serial input
//   tx        serial output, idle high
//
// TX/RX FSM states:
//   state  | meaning
//   IDLE   | line idle (TX: waiting for a FIFO entry, RX: waiting for a falling edge)
//   START  | start bit (RX: waits half a bit, then checks the line is still low)
//   DATA   | 8 data bits, LSB first
//   STOP   | stop bit
//   WAIT   | RX only: stop bit read 0, waits for the line to return high
module mmio_uart_fifo #(
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter logic [15:0] DIV_RESET = 16'd234
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] wdata,
  input  logic        wstrb,
  input  logic        rstrb,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        rx,
  output logic        tx
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic [7:0]  r_txq [TX_DEPTH];
  logic [TAW-1:0] r_txq_wp, r_txq_rp;
  logic [TAW:0]   r_txq_cnt;
  logic [7:0]  r_rxq [RX_DEPTH];
  logic [RAW-1:0] r_rxq_wp, r_rxq_rp;
  logic [RAW:0]   r_rxq_cnt;

  logic [15:0] r_div;
  logic [1:0]  r_irq_en;
  logic        r_tx_ovf, r_rx_ovr, r_frame_err;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;

  tx_state_t   r_tx_state, w_tx_nstate;
  logic [15:0] r_tx_cnt, w_tx_ncnt, r_tx_div, w_tx_ndiv;
  logic [2:0]  r_tx_bit, w_tx_nbit;
  logic [7:0]  r_tx_shift, w_tx_nshift;
  logic        w_txq_pop;

  rx_state_t   r_rx_state, w_rx_nstate;
  logic [15:0] r_rx_cnt, w_rx_ncnt, r_rx_div, w_rx_ndiv;
  logic [2:0]  r_rx_bit, w_rx_nbit;
  logic [7:0]  r_rx_shift, w_rx_nshift;
  logic        w_rx_done, w_rx_ferr;

  logic w_wr_data, w_wr_stat, w_wr_div, w_wr_irq, w_rd_data;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_tx_busy, w_rx_fall;
  logic w_txq_push, w_rxq_push, w_rxq_pop, w_tx_ovf_set, w_rx_ovr_set;
  logic [7:0]  w_rx_cnt8;
  logic [31:0] w_rd_val;
  logic        w_unused_wdata;

  assign w_wr_data = sel & wstrb & (reg_addr == 2'd0);
  assign w_wr_stat = sel & wstrb & (reg_addr == 2'd1);
  assign w_wr_div  = sel & wstrb & (reg_addr == 2'd2);
  assign w_wr_irq  = sel & wstrb & (reg_addr == 2'd3);
  assign w_rd_data = sel & rstrb & (reg_addr == 2'd0);
  assign w_unused_wdata = ^wdata[31:16];

  // Full/empty come from the registered counts, so a push to a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign w_tx_full  = (r_txq_cnt == (TAW+1)'(TX_DEPTH));
  assign w_tx_empty = (r_txq_cnt == '0);
  assign w_rx_full  = (r_rxq_cnt == (RAW+1)'(RX_DEPTH));
  assign w_rx_empty = (r_rxq_cnt == '0);
  assign w_tx_busy  = (r_tx_state != TX_IDLE);
  assign w_rx_cnt8  = 8'(r_rxq_cnt);
  assign w_rx_fall  = r_rx_prev & ~r_rx_s2;

  assign w_txq_push   = w_wr_data & ~w_tx_full;
  assign w_tx_ovf_set = w_wr_data & w_tx_full;
  assign w_rxq_push   = w_rx_done & ~w_rx_full;
  assign w_rx_ovr_set = w_rx_done & w_rx_full;
  assign w_rxq_pop    = w_rd_data & ~w_rx_empty;

  assign tx = (r_tx_state == TX_START) ? 1'b0 :
              (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;

  always_comb begin
    w_tx_nstate = r_tx_state;
    w_tx_ncnt   = r_tx_cnt;
    w_tx_ndiv   = r_tx_div;
    w_tx_nbit   = r_tx_bit;
    w_tx_nshift = r_tx_shift;
    w_txq_pop   = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_tx_empty) begin
        w_txq_pop   = 1'b1;
        w_tx_nshift = r_txq[r_txq_rp];
        w_tx_ndiv   = r_div;
        w_tx_ncnt   = r_div - 16'd1;
        w_tx_nstate = TX_START;
      end
      TX_START: if (r_tx_cnt == 16'd0) begin
        w_tx_nstate = TX_DATA;
        w_tx_ncnt   = r_tx_div - 16'd1;
        w_tx_nbit   = 3'd0;
      end else w_tx_ncnt = r_tx_cnt - 16'd1;
      TX_DATA: if (r_tx_cnt == 16'd0) begin
        w_tx_ncnt   = r_tx_div - 16'd1;
        w_tx_nshift = r_tx_shift >> 1;
        if (r_tx_bit == 3'd7) w_tx_nstate = TX_STOP;
        else w_tx_nbit = r_tx_bit + 3'd1;
      end else w_tx_ncnt = r_tx_cnt - 16'd1;
      TX_STOP: if (r_tx_cnt == 16'd0) w_tx_nstate = TX_IDLE;
               else w_tx_ncnt = r_tx_cnt - 16'd1;
      default: w_tx_nstate = TX_IDLE;
    endcase
  end

  // RX checks the start bit half a bit after the edge, then samples every
  // bit period so that each sample lands mid-bit.
  always_comb begin
    w_rx_nstate = r_rx_state;
    w_rx_ncnt   = r_rx_cnt;
    w_rx_ndiv   = r_rx_div;
    w_rx_nbit   = r_rx_bit;
    w_rx_nshift = r_rx_shift;
    w_rx_done   = 1'b0;
    w_rx_ferr   = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (w_rx_fall) begin
        w_rx_ndiv   = r_div;
        w_rx_ncnt   = (r_div >> 1) - 16'd1;
        w_rx_nstate = RX_START;
      end
      RX_START: if (r_rx_cnt == 16'd0) begin
        if (!r_rx_s2) begin
          w_rx_nstate = RX_DATA;
          w_rx_ncnt   = r_rx_div - 16'd1;
          w_rx_nbit   = 3'd0;
        end else w_rx_nstate = RX_IDLE;
      end else w_rx_ncnt = r_rx_cnt - 16'd1;
      RX_DATA: if (r_rx_cnt == 16'd0) begin
        w_rx_nshift = {r_rx_s2, r_rx_shift[7:1]};
        w_rx_ncnt   = r_rx_div - 16'd1;
        if (r_rx_bit == 3'd7) w_rx_nstate = RX_STOP;
        else w_rx_nbit = r_rx_bit + 3'd1;
      end else w_rx_ncnt = r_rx_cnt - 16'd1;
      RX_STOP: if (r_rx_cnt == 16'd0) begin
        if (r_rx_s2) begin
          w_rx_done   = 1'b1;
          w_rx_nstate = RX_IDLE;
        end else begin
          w_rx_ferr   = 1'b1;
          w_rx_nstate = RX_WAIT;
        end
      end else w_rx_ncnt = r_rx_cnt - 16'd1;
      RX_WAIT: if (r_rx_s2) w_rx_nstate = RX_IDLE;
      default: w_rx_nstate = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rd_val = 32'd0;
    case (reg_addr)
      2'd0: if (!w_rx_empty) w_rd_val = {23'd0, 1'b1, r_rxq[r_rxq_rp]};
      2'd1: w_rd_val = {16'd0, w_rx_cnt8, r_tx_ovf, r_frame_err, r_rx_ovr, w_tx_busy,
                        w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
      2'd2: w_rd_val = {16'd0, r_div};
      default: w_rd_val = {30'd0, r_irq_en};
    endcase
  end

  // FIFO storage has no reset; the pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (w_txq_push) r_txq[r_txq_wp] <= wdata[7:0];
    if (w_rxq_push) r_rxq[r_rxq_wp] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_txq_wp <= '0; r_txq_rp <= '0; r_txq_cnt <= '0;
      r_rxq_wp <= '0; r_rxq_rp <= '0; r_rxq_cnt <= '0;
      r_div <= DIV_RESET; r_irq_en <= 2'b00;
      r_tx_ovf <= 1'b0; r_rx_ovr <= 1'b0; r_frame_err <= 1'b0;
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
      r_tx_state <= TX_IDLE; r_tx_cnt <= '0; r_tx_div <= DIV_RESET;
      r_tx_bit <= '0; r_tx_shift <= '0;
      r_rx_state <= RX_IDLE; r_rx_cnt <= '0; r_rx_div <= DIV_RESET;
      r_rx_bit <= '0; r_rx_shift <= '0;
      rdata <= 32'd0; irq <= 1'b0;
    end else begin
      if (w_txq_push) r_txq_wp <= r_txq_wp + 1'b1;
      if (w_txq_pop)  r_txq_rp <= r_txq_rp + 1'b1;
      case ({w_txq_push, w_txq_pop})
        2'b10:   r_txq_cnt <= r_txq_cnt + 1'b1;
        2'b01:   r_txq_cnt <= r_txq_cnt - 1'b1;
        default: r_txq_cnt <= r_txq_cnt;
      endcase
      if (w_rxq_push) r_rxq_wp <= r_rxq_wp + 1'b1;
      if (w_rxq_pop)  r_rxq_rp <= r_rxq_rp + 1'b1;
      case ({w_rxq_push, w_rxq_pop})
        2'b10:   r_rxq_cnt <= r_rxq_cnt + 1'b1;
        2'b01:   r_rxq_cnt <= r_rxq_cnt - 1'b1;
        default: r_rxq_cnt <= r_rxq_cnt;
      endcase
      if (w_wr_div) r_div <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
      if (w_wr_irq) r_irq_en <= wdata[1:0];
      // A new event in the same cycle as its clear keeps the flag set.
      r_rx_ovr    <= w_rx_ovr_set | (r_rx_ovr    & ~(w_wr_stat & wdata[5]));
      r_frame_err <= w_rx_ferr    | (r_frame_err & ~(w_wr_stat & wdata[6]));
      r_tx_ovf    <= w_tx_ovf_set | (r_tx_ovf    & ~(w_wr_stat & wdata[7]));
      r_rx_s1 <= rx; r_rx_s2 <= r_rx_s1; r_rx_prev <= r_rx_s2;
      r_tx_state <= w_tx_nstate; r_tx_cnt <= w_tx_ncnt; r_tx_div <= w_tx_ndiv;
      r_tx_bit <= w_tx_nbit; r_tx_shift <= w_tx_nshift;
      r_rx_state <= w_rx_nstate; r_rx_cnt <= w_rx_ncnt; r_rx_div <= w_rx_ndiv;
      r_rx_bit <= w_rx_nbit; r_rx_shift <= w_rx_nshift;
      if (sel & rstrb) rdata <= w_rd_val;
      irq <= (r_irq_en[0] & ~w_rx_empty) | (r_irq_en[1] & w_tx_empty);
    end
  end
endmodule
